// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC data bus: slave indices, decode windows, arbiter FSM states.
package soc_bus_pkg;

    localparam int unsigned RAM       = 0;
    localparam int unsigned UART      = 1;
    localparam int unsigned PORT      = 2;
    localparam int unsigned PERI_SIZE = 3;

    // Windows are compared against addr[RAM_ADDRW:0] once the address is outside RAM.
    localparam int unsigned UART_LO = 32'h402;
    localparam int unsigned UART_HI = 32'h403;
    localparam int unsigned PORT_LO = 32'h404;
    localparam int unsigned PORT_HI = 32'h406;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_e;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational slave decode: address to one-hot slave select plus a miss flag.
module bus_addr_decode
    import soc_bus_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAM_ADDRW = 10
) (
    input  logic [XLEN-1:0]      i_addr,
    output logic [PERI_SIZE-1:0] o_sel,
    output logic                 o_miss
);

    logic                 w_ram_hit;
    logic [RAM_ADDRW:0]   w_low;
    int unsigned          w_low_u;

    assign w_ram_hit = (i_addr[XLEN-1:RAM_ADDRW] == '0);
    assign w_low     = i_addr[RAM_ADDRW:0];
    assign w_low_u   = int'(w_low);

    always_comb begin
        o_sel = '0;
        if (w_ram_hit) begin
            o_sel[RAM] = 1'b1;
        end else if (w_low_u >= UART_LO && w_low_u <= UART_HI) begin
            o_sel[UART] = 1'b1;
        end else if (w_low_u >= PORT_LO && w_low_u <= PORT_HI) begin
            o_sel[PORT] = 1'b1;
        end
        o_miss = ~|o_sel;
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin data-bus arbiter with slave decode, read-wait timeout and error return.
module data_bus_arbiter
    import soc_bus_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     RAM_ADDRW = 10,
    parameter int unsigned     TIMEOUT   = 15,
    parameter logic [XLEN-1:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                           clk,
    input  logic                           rstB,
    input  logic [1:0]                     m_req,
    input  logic [1:0]                     m_we,
    input  logic [1:0][XLEN-1:0]           m_addr,
    input  logic [1:0][XLEN-1:0]           m_wdata,
    input  logic [1:0][3:0]                m_mode,
    output logic [1:0]                     m_ack,
    output logic [XLEN-1:0]                m_rdata,
    output logic [1:0]                     m_err,
    output logic [XLEN-1:0]                s_addr,
    output logic [XLEN-1:0]                s_wdata,
    output logic [3:0]                     s_mode,
    output logic                           s_wrEn,
    output logic [PERI_SIZE-1:0]           s_rdEn,
    input  logic [PERI_SIZE-1:0][XLEN-1:0] s_dataOut,
    input  logic [PERI_SIZE-1:0]           s_outEn
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    arb_state_e     r_state;
    arb_state_e     w_state_nxt;
    logic           r_last;
    logic           r_gnt;
    logic           r_we;
    logic [CW-1:0]  r_cnt;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]     r_mode;

    logic                 w_both;
    logic                 w_gnt;
    logic [PERI_SIZE-1:0] w_sel;
    logic                 w_miss;
    logic                 w_hit;
    logic [XLEN-1:0]      w_hit_data;
    logic                 w_done;
    logic                 w_err;

    assign w_both = &m_req;
    // Contention goes to the loser of the previous contention; a lone request wins outright.
    assign w_gnt  = w_both ? ~r_last : m_req[1];

    bus_addr_decode #(
        .XLEN      (XLEN),
        .RAM_ADDRW (RAM_ADDRW)
    ) u_decode (
        .i_addr (r_addr),
        .o_sel  (w_sel),
        .o_miss (w_miss)
    );

    assign w_hit = |(s_outEn & w_sel);

    always_comb begin
        w_hit_data = '0;
        for (int k = 0; k < PERI_SIZE; k++) begin
            if (w_sel[k]) begin
                w_hit_data = w_hit_data | s_dataOut[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mode  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == WAIT) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
            if (r_state == IDLE && |m_req) begin
                r_gnt   <= w_gnt;
                r_we    <= m_we[w_gnt];
                r_addr  <= m_addr[w_gnt];
                r_wdata <= m_wdata[w_gnt];
                r_mode  <= m_mode[w_gnt];
                if (w_both) begin
                    r_last <= w_gnt;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_err       = 1'b0;
        m_rdata     = '0;
        s_wrEn      = 1'b0;
        s_rdEn      = '0;
        unique case (r_state)
            IDLE: begin
                if (|m_req) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (r_we) begin
                    // Slaves self-decode, so a miss still strobes and is flagged as an error.
                    s_wrEn      = 1'b1;
                    w_done      = 1'b1;
                    w_err       = w_miss;
                    w_state_nxt = IDLE;
                end else if (w_miss) begin
                    w_done      = 1'b1;
                    w_err       = 1'b1;
                    m_rdata     = ERR_DATA;
                    w_state_nxt = IDLE;
                end else begin
                    s_rdEn      = w_sel;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_hit) begin
                    w_done      = 1'b1;
                    m_rdata     = w_hit_data;
                    w_state_nxt = IDLE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_done      = 1'b1;
                    w_err       = 1'b1;
                    m_rdata     = ERR_DATA;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_ack        = '0;
        m_err        = '0;
        m_ack[r_gnt] = w_done;
        m_err[r_gnt] = w_done & w_err;
    end

    assign s_addr  = r_addr;
    assign s_wdata = r_wdata;
    assign s_mode  = r_mode;

endmodule
